// File: rtl/enemy_bullet_controller.sv
// enemy_bullet_controller
//   Spawns enemy bullets from alive shooters, moves them down the 640x480
//   field, detects hits on the 32x32 player sprite, and owns the player's
//   life count, post-hit invulnerability window and game-over flag.
//
// Ports
//   clk25               25 MHz pixel-domain clock
//   rst_n               asynchronous active-low reset
//   enable              spawning allowed (existing bullets always move)
//   clear_all           synchronous stage reset (bullets, lives, FSM, timers)
//   shooter_x_flat/_y_  shooter top-left positions, 10 bits per shooter
//   shooter_alive       per-shooter alive flag
//   player_x/player_y   player sprite top-left position
//   ebullet_x_flat/_y_  bullet top-left positions, 10 bits per slot
//   ebullet_active_flat per-slot active flag
//   player_hit          one-cycle pulse per counted hit
//   lives               remaining lives
//   invuln              high while invulnerable after a hit
//   game_over           high once the last life is lost
//
// Build option
//   AIMED_FIRE_EN       when defined, each bullet drifts 1 px per move tick
//                       toward the side the player was on at spawn time;
//                       otherwise bullets fall straight down.
//
// FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_RUN    | normal play, hits cost a life
//   ST_INVULN | post-hit grace window, hits only clear the bullet
//   ST_OVER   | no lives left, bullets flushed, spawning stopped
module enemy_bullet_controller #(
  parameter int EBULLET_COUNT = 8,
  parameter int SHOOTER_COUNT = 8,
  parameter int FIRE_PERIOD   = 12500000,
  parameter int MOVE_DIV      = 250000,
  parameter int SPEED         = 2,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_TICKS  = 100
) (
  input  logic                        clk25,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear_all,
  input  logic [10*SHOOTER_COUNT-1:0] shooter_x_flat,
  input  logic [10*SHOOTER_COUNT-1:0] shooter_y_flat,
  input  logic [SHOOTER_COUNT-1:0]    shooter_alive,
  input  logic [9:0]                  player_x,
  input  logic [9:0]                  player_y,
  output logic [10*EBULLET_COUNT-1:0] ebullet_x_flat,
  output logic [10*EBULLET_COUNT-1:0] ebullet_y_flat,
  output logic [EBULLET_COUNT-1:0]    ebullet_active_flat,
  output logic                        player_hit,
  output logic [1:0]                  lives,
  output logic                        invuln,
  output logic                        game_over
);

  localparam int FW = (FIRE_PERIOD > 1)   ? $clog2(FIRE_PERIOD)   : 1;
  localparam int MW = (MOVE_DIV > 1)      ? $clog2(MOVE_DIV)      : 1;
  localparam int IW = (INVULN_TICKS > 1)  ? $clog2(INVULN_TICKS)  : 1;
  localparam int RW = (SHOOTER_COUNT > 1) ? $clog2(SHOOTER_COUNT) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_INVULN, ST_OVER} state_t;

  state_t                          state_q, state_d;
  logic [1:0]                      lives_q, lives_d;
  logic [FW-1:0]                   fire_cnt_q, fire_cnt_d;
  logic [MW-1:0]                   move_cnt_q, move_cnt_d;
  logic [IW-1:0]                   inv_cnt_q, inv_cnt_d;
  logic [RW-1:0]                   rr_q, rr_d;
  logic                            hit_q, hit_d;
  logic                            invuln_q, invuln_d;
  logic                            over_q, over_d;
  logic [EBULLET_COUNT-1:0]        act_q, act_d;
  logic [EBULLET_COUNT-1:0][9:0]   bx_q, bx_d;
  logic [EBULLET_COUNT-1:0][9:0]   by_q, by_d;
`ifdef AIMED_FIRE_EN
  logic [EBULLET_COUNT-1:0]        dir_q, dir_d;
`endif

  logic                            fire_wrap, move_tick, spawn, any_hit;
  logic [EBULLET_COUNT-1:0]        ovl;
  logic [SHOOTER_COUNT-1:0]        rot_alive;
  logic [9:0]                      spawn_sx, spawn_sy, spawn_x, spawn_y;
  logic [RW-1:0]                   rr_next;
  logic [10:0]                     y_sum;
  int                              shooter_off, shooter_sel, spawn_slot;

  assign fire_wrap = (fire_cnt_q == FW'(FIRE_PERIOD - 1));
  assign move_tick = (move_cnt_q == MW'(MOVE_DIV - 1));

  // Overlap of each active bullet (8x8) with the player (32x32), 11-bit math.
  always_comb begin
    ovl = '0;
    for (int i = 0; i < EBULLET_COUNT; i++) begin
      ovl[i] = act_q[i] &&
               (({1'b0, bx_q[i]} + 11'd8) > {1'b0, player_x}) &&
               ({1'b0, bx_q[i]} < ({1'b0, player_x} + 11'd32)) &&
               (({1'b0, by_q[i]} + 11'd8) > {1'b0, player_y}) &&
               ({1'b0, by_q[i]} < ({1'b0, player_y} + 11'd32));
    end
  end
  assign any_hit = |ovl;

  // Round-robin shooter pick: rotate alive mask so bit 0 is the pointer,
  // take the lowest set bit, then map back to an absolute index.
  always_comb begin
    rot_alive   = SHOOTER_COUNT'({shooter_alive, shooter_alive} >> rr_q);
    shooter_off = 0;
    for (int k = SHOOTER_COUNT - 1; k >= 0; k--) begin
      if (rot_alive[k]) shooter_off = k;
    end
    shooter_sel = int'(rr_q) + shooter_off;
    if (shooter_sel >= SHOOTER_COUNT) shooter_sel = shooter_sel - SHOOTER_COUNT;
    spawn_sx = '0;
    spawn_sy = '0;
    for (int k = 0; k < SHOOTER_COUNT; k++) begin
      if (k == shooter_sel) begin
        spawn_sx = shooter_x_flat[10*k +: 10];
        spawn_sy = shooter_y_flat[10*k +: 10];
      end
    end
    rr_next = (shooter_sel == SHOOTER_COUNT - 1) ? '0 : RW'(shooter_sel + 1);
    spawn_slot = 0;
    for (int k = EBULLET_COUNT - 1; k >= 0; k--) begin
      if (!act_q[k]) spawn_slot = k;
    end
  end

  assign spawn_x = spawn_sx + 10'd12;
  assign spawn_y = spawn_sy + 10'd32;
  // Free mask is the registered active bits, so a slot cleared this cycle
  // can never be picked for a spawn in the same cycle.
  assign spawn   = fire_wrap && enable && (state_q != ST_OVER) &&
                   !(&act_q) && (|shooter_alive) && !clear_all;

  // Control FSM, timers, lives.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    inv_cnt_d  = inv_cnt_q;
    hit_d      = 1'b0;
    rr_d       = rr_q;
    fire_cnt_d = fire_wrap ? '0 : fire_cnt_q + FW'(1);
    move_cnt_d = move_tick ? '0 : move_cnt_q + MW'(1);
    if (clear_all) begin
      state_d    = ST_RUN;
      lives_d    = 2'(LIVES_INIT);
      inv_cnt_d  = '0;
      rr_d       = '0;
      fire_cnt_d = '0;
      move_cnt_d = '0;
    end else begin
      if (spawn) rr_d = rr_next;
      case (state_q)
        ST_RUN: begin
          if (any_hit) begin
            hit_d     = 1'b1;
            inv_cnt_d = '0;
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = ST_OVER;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = ST_INVULN;
            end
          end
        end
        ST_INVULN: begin
          if (move_tick) begin
            if (inv_cnt_q == IW'(INVULN_TICKS - 1)) begin
              inv_cnt_d = '0;
              state_d   = ST_RUN;
            end else begin
              inv_cnt_d = inv_cnt_q + IW'(1);
            end
          end
        end
        default: state_d = ST_OVER;
      endcase
    end
    invuln_d = (state_d == ST_INVULN);
    over_d   = (state_d == ST_OVER);
  end

  // Per-slot update: clear > move > spawn.
  always_comb begin
    act_d = act_q;
    bx_d  = bx_q;
    by_d  = by_q;
    y_sum = '0;
`ifdef AIMED_FIRE_EN
    dir_d = dir_q;
`endif
    for (int i = 0; i < EBULLET_COUNT; i++) begin
      y_sum = {1'b0, by_q[i]} + 11'(SPEED);
      if (clear_all || (state_q == ST_OVER) || ovl[i]) begin
        act_d[i] = 1'b0;
        bx_d[i]  = '0;
        by_d[i]  = '0;
      end else if (act_q[i] && move_tick) begin
        if (y_sum >= 11'd472) begin
          act_d[i] = 1'b0;
          bx_d[i]  = '0;
          by_d[i]  = '0;
        end else begin
          by_d[i] = y_sum[9:0];
`ifdef AIMED_FIRE_EN
          if (dir_q[i]) begin
            bx_d[i] = (bx_q[i] >= 10'd632) ? 10'd632 : bx_q[i] + 10'd1;
          end else begin
            bx_d[i] = (bx_q[i] == 10'd0) ? 10'd0 : bx_q[i] - 10'd1;
          end
`endif
        end
      end else if (spawn && (i == spawn_slot)) begin
        act_d[i] = 1'b1;
        bx_d[i]  = spawn_x;
        by_d[i]  = spawn_y;
`ifdef AIMED_FIRE_EN
        dir_d[i] = ({1'b0, player_x} + 11'd12) > {1'b0, spawn_x};
`endif
      end
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      lives_q    <= 2'(LIVES_INIT);
      fire_cnt_q <= '0;
      move_cnt_q <= '0;
      inv_cnt_q  <= '0;
      rr_q       <= '0;
      hit_q      <= 1'b0;
      invuln_q   <= 1'b0;
      over_q     <= 1'b0;
      act_q      <= '0;
      bx_q       <= '0;
      by_q       <= '0;
`ifdef AIMED_FIRE_EN
      dir_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      fire_cnt_q <= fire_cnt_d;
      move_cnt_q <= move_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      rr_q       <= rr_d;
      hit_q      <= hit_d;
      invuln_q   <= invuln_d;
      over_q     <= over_d;
      act_q      <= act_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
`ifdef AIMED_FIRE_EN
      dir_q      <= dir_d;
`endif
    end
  end

  assign ebullet_x_flat      = bx_q;
  assign ebullet_y_flat      = by_q;
  assign ebullet_active_flat = act_q;
  assign player_hit          = hit_q;
  assign lives               = lives_q;
  assign invuln              = invuln_q;
  assign game_over           = over_q;

endmodule
